axi_rd_master_engine: RTL and testbench

Parametrised AXI4 read-channel master engine: it accepts read commands on a simple valid/ready command port, issues them as AR bursts with up to `MAX_OUT` transactions outstanding, and returns read beats through a 2-entry registered skid buffer. It is the synthesizable successor to the testbench-only AXI read master interface. It sits between a local requester (DMA, bench driver) and an interconnect master port. It adds command legality checks, outstanding tracking, response error counting and an optional burst-length protocol checker.

---
 rtl/axi_rd_master_engine_if.sv | 50 +++++
 rtl/axi_rd_master_engine.sv | 160 ++++++++++++++++
 tb/tb_axi_rd_master_engine.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_rd_master_engine_if.sv
// Bundled command / AR / R / returned-beat signals of the AXI read master engine.
// master = engine side, slave = requester plus interconnect side.
interface axi_rd_master_engine_if #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 8,
  parameter int SIZE_W = 3,
  parameter int DATA_W = 32
);
  logic              cmd_valid, cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic [SIZE_W-1:0] cmd_size;
  logic [1:0]        cmd_burst;

  logic [ADDR_W-1:0] araddr;
  logic [LEN_W-1:0]  arlen;
  logic [SIZE_W-1:0] arsize;
  logic [1:0]        arburst;
  logic              arvalid, arready;

  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast, rvalid, rready;

  logic [DATA_W-1:0] out_data;
  logic [1:0]        out_resp;
  logic              out_last, out_valid, out_ready;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, cmd_size, cmd_burst,
    output cmd_ready,
    output araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready,
    output out_data, out_resp, out_last, out_valid,
    input  out_ready
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, cmd_size, cmd_burst,
    input  cmd_ready,
    input  araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready,
    input  out_data, out_resp, out_last, out_valid,
    output out_ready
  );
endinterface

// File: rtl/axi_rd_master_engine.sv
// AXI4 read master engine: command legality check, AR issue with up to MAX_OUT outstanding,
// 2-entry R skid buffer. Define AXI_RD_PROTO_CHECK_EN to add the burst-length protocol checker.
module axi_rd_master_engine #(
  parameter int  ADDR_W  = 32,
  parameter int  LEN_W   = 8,
  parameter int  SIZE_W  = 3,
  parameter int  DATA_W  = 32,
  parameter int  MAX_OUT = 4,
  localparam int OUT_W   = $clog2(MAX_OUT + 1)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  axi_rd_master_engine_if.master bus,
  output logic                   cmd_err,
  output logic [OUT_W-1:0]       outstanding,
  output logic [15:0]            resp_err_cnt,
  output logic                   proto_err
);
  localparam int MAX_SIZE = $clog2(DATA_W / 8);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
  } beat_t;

  logic        accept, legal, ar_hs, r_hs, retire, push, pop;
  logic [11:0] size_mask;
  logic [31:0] span, base_off;
  beat_t       ent0, ent1, r_in;
  logic [1:0]  fill;

  // 4 KB check uses the size-aligned start, as the bus sees an unaligned INCR.
  always_comb begin
    size_mask = (12'd1 << bus.cmd_size) - 12'd1;
    base_off  = {20'd0, bus.cmd_addr[11:0] & ~size_mask};
    span      = (32'(bus.cmd_len) + 32'd1) << bus.cmd_size;
    legal     = (bus.cmd_size <= SIZE_W'(MAX_SIZE));
    case (bus.cmd_burst)
      2'b01: if (base_off + span > 32'd4096) legal = 1'b0;
      2'b10: if (!(bus.cmd_len inside {1, 3, 7, 15}) ||
                 ((bus.cmd_addr[11:0] & size_mask) != 12'd0)) legal = 1'b0;
      2'b11: legal = 1'b0;
      default: ;
    endcase
  end

  assign bus.cmd_ready = reset_n && !bus.arvalid && (outstanding < OUT_W'(MAX_OUT));
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign ar_hs         = bus.arvalid && bus.arready;
  assign r_hs          = bus.rvalid && bus.rready;

`ifdef AXI_RD_PROTO_CHECK_EN
  localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  logic [LEN_W-1:0] len_fifo [MAX_OUT];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LEN_W-1:0] beat_cnt;
  logic             exp_last;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + 1'b1;
  endfunction

  assign exp_last = (outstanding != '0) && (beat_cnt == len_fifo[rd_ptr]);
  assign retire   = r_hs && exp_last;

  always_ff @(posedge clk)
    if (ar_hs) len_fifo[wr_ptr] <= bus.arlen;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      beat_cnt  <= '0;
      proto_err <= 1'b0;
    end else begin
      if (ar_hs) wr_ptr <= ptr_inc(wr_ptr);
      if (retire) begin
        rd_ptr   <= ptr_inc(rd_ptr);
        beat_cnt <= '0;
      end else if (r_hs && outstanding != '0) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
      // Early/late rlast, or a beat with nothing outstanding.
      if (r_hs && (outstanding == '0 || bus.rlast != exp_last)) proto_err <= 1'b1;
    end
  end
`else
  assign retire    = r_hs && bus.rlast && (outstanding != '0);
  assign proto_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.arvalid  <= 1'b0;
      bus.araddr   <= '0;
      bus.arlen    <= '0;
      bus.arsize   <= '0;
      bus.arburst  <= '0;
      cmd_err      <= 1'b0;
      outstanding  <= '0;
      resp_err_cnt <= '0;
    end else begin
      cmd_err <= accept && !legal;
      if (accept && legal) begin
        bus.arvalid <= 1'b1;
        bus.araddr  <= bus.cmd_addr;
        bus.arlen   <= bus.cmd_len;
        bus.arsize  <= bus.cmd_size;
        bus.arburst <= bus.cmd_burst;
      end else if (ar_hs) begin
        bus.arvalid <= 1'b0;
      end
      if (ar_hs && !retire)      outstanding <= outstanding + 1'b1;
      else if (retire && !ar_hs) outstanding <= outstanding - 1'b1;
      if (r_hs && bus.rresp != 2'b00 && resp_err_cnt != 16'hFFFF)
        resp_err_cnt <= resp_err_cnt + 16'd1;
    end
  end

  // Skid buffer: ent0 is the head shown on out_*, ent1 the second slot.
  assign bus.rready    = reset_n && (fill < 2'd2);
  assign push          = r_hs;
  assign pop           = bus.out_valid && bus.out_ready;
  assign r_in          = '{data: bus.rdata, resp: bus.rresp, last: bus.rlast};
  assign bus.out_valid = (fill != 2'd0);
  assign bus.out_data  = ent0.data;
  assign bus.out_resp  = ent0.resp;
  assign bus.out_last  = ent0.last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ent0 <= '0;
      ent1 <= '0;
      fill <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (fill == 2'd0) ent0 <= r_in;
          else              ent1 <= r_in;
          fill <= fill + 2'd1;
        end
        2'b01: begin
          ent0 <= ent1;
          fill <= fill - 2'd1;
        end
        2'b11: begin
          if (fill == 2'd2) begin
            ent0 <= ent1;
            ent1 <= r_in;
          end else begin
            ent0 <= r_in;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_rd_master_engine.sv
// Bench for axi_rd_master_engine: legality vector table, hand sequences, and random traffic
// checked every cycle against a queue-based reference model.
module tb_axi_rd_master_engine;
  localparam int ADDR_W = 32, LEN_W = 8, SIZE_W = 3, DATA_W = 32, MAX_OUT = 4;
  localparam int OUT_W = $clog2(MAX_OUT + 1);
`ifdef AXI_RD_PROTO_CHECK_EN
  localparam bit PROTO_EXP = 1'b1;
`else
  localparam bit PROTO_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  axi_rd_master_engine_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .SIZE_W(SIZE_W), .DATA_W(DATA_W)) bus ();

  logic             cmd_err, proto_err;
  logic [OUT_W-1:0] outstanding;
  logic [15:0]      resp_err_cnt;

  axi_rd_master_engine #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .SIZE_W(SIZE_W), .DATA_W(DATA_W),
                         .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .cmd_err(cmd_err),
    .outstanding(outstanding), .resp_err_cnt(resp_err_cnt), .proto_err(proto_err));

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
  } beat_t;

  typedef struct {
    logic [31:0] addr;
    int len, size, burst;
    bit err;
  } vec_t;

  int checks = 0, failures = 0;

  // reference model state
  beat_t             mq[$];
  bit                m_arv, m_proto, m_cerr;
  logic [ADDR_W-1:0] m_addr;
  logic [LEN_W-1:0]  m_len;
  logic [SIZE_W-1:0] m_size;
  logic [1:0]        m_burst;
  int                m_out, m_rec, m_bcnt;
  int                m_lenq[$];
  // bench slave state
  int sq[$];
  int s_beat, err_pct;
  int dut_ar_cnt, dut_r_cnt;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string nm);
    checks++;
    failures++;
    $display("FAIL %s timeout at %0t", nm, $time);
  endtask

  function automatic bit model_crdy();
    return !m_arv && m_out < MAX_OUT;
  endfunction

  function automatic bit legal_cmd(input logic [31:0] a, input int len, input int size, input int burst);
    int bytes = 1 << size;
    int lo = int'(a[11:0]);
    if (bytes > DATA_W / 8) return 1'b0;
    if (burst == 3) return 1'b0;
    if (burst == 2) return (len == 1 || len == 3 || len == 7 || len == 15) && (lo % bytes == 0);
    if (burst == 1) return (lo - lo % bytes) + (len + 1) * bytes <= 4096;
    return 1'b1;
  endfunction

  task automatic model_reset();
    mq.delete(); m_lenq.delete(); sq.delete();
    m_arv = 0; m_proto = 0; m_cerr = 0;
    m_addr = '0; m_len = '0; m_size = '0; m_burst = '0;
    m_out = 0; m_rec = 0; m_bcnt = 0; s_beat = 0;
  endtask

  task automatic compare();
    chk("cmd_ready", bus.cmd_ready, model_crdy());
    chk("arvalid", bus.arvalid, m_arv);
    if (m_arv) begin
      chk("araddr", bus.araddr, m_addr);
      chk("arlen", bus.arlen, m_len);
      chk("arsize", bus.arsize, m_size);
      chk("arburst", bus.arburst, m_burst);
    end
    chk("rready", bus.rready, mq.size() < 2);
    chk("out_valid", bus.out_valid, mq.size() > 0);
    if (mq.size() > 0) chk("out_beat", {bus.out_data, bus.out_resp, bus.out_last}, mq[0]);
    chk("outstanding", outstanding, m_out);
    chk("resp_err_cnt", resp_err_cnt, m_rec);
    chk("proto_err", proto_err, m_proto);
    chk("cmd_err", cmd_err, m_cerr);
  endtask

  // Advance the model across the next rising edge using the inputs now driven, then check.
  task automatic tick();
    bit arhs, rhs, ohs, ret, acc, lg;
    beat_t b;
    arhs = m_arv && bus.arready;
    rhs  = bus.rvalid && mq.size() < 2;
    ohs  = mq.size() > 0 && bus.out_ready;
    acc  = bus.cmd_valid && model_crdy();
    lg   = legal_cmd(bus.cmd_addr, int'(bus.cmd_len), int'(bus.cmd_size), int'(bus.cmd_burst));
    if (bus.arvalid && bus.arready) dut_ar_cnt++;
    if (bus.rvalid && bus.rready) dut_r_cnt++;
`ifdef AXI_RD_PROTO_CHECK_EN
    ret = rhs && m_lenq.size() > 0 && m_bcnt == m_lenq[0];
    if (rhs && (m_out == 0 || bus.rlast != ret)) m_proto = 1;
    if (ret) begin
      void'(m_lenq.pop_front());
      m_bcnt = 0;
    end else if (rhs && m_out > 0) m_bcnt++;
    if (arhs) m_lenq.push_back(int'(m_len));
`else
    ret = rhs && bus.rlast && m_out > 0;
`endif
    if (arhs) sq.push_back(int'(m_len));
    m_out = m_out + int'(arhs) - int'(ret);
    if (rhs && bus.rresp != 2'b00 && m_rec < 65535) m_rec++;
    m_cerr = acc && !lg;
    if (acc && lg) begin
      m_arv = 1; m_addr = bus.cmd_addr; m_len = bus.cmd_len;
      m_size = bus.cmd_size; m_burst = bus.cmd_burst;
    end else if (arhs) m_arv = 0;
    b.data = bus.rdata; b.resp = bus.rresp; b.last = bus.rlast;
    if (ohs) void'(mq.pop_front());
    if (rhs) mq.push_back(b);
    if (rhs) begin
      if (bus.rlast) begin
        if (sq.size() > 0) void'(sq.pop_front());
        s_beat = 0;
      end else s_beat++;
    end
    @(negedge clk);
    compare();
    if (rhs) bus.rvalid = 1'b0;
  endtask

  task automatic slave_step(input int pct);
    if (bus.rvalid) return;
    if (sq.size() > 0 && int'($urandom_range(99)) < pct) begin
      bus.rvalid = 1'b1;
      bus.rdata  = $urandom;
      bus.rresp  = (int'($urandom_range(99)) < err_pct) ? 2'($urandom_range(1, 3)) : 2'b00;
      bus.rlast  = (s_beat == sq[0]);
    end
  endtask

  task automatic send_cmd(input logic [31:0] a, input int len, input int size, input int burst);
    int n = 0;
    while (!model_crdy() && n < 200) begin tick(); n++; end
    if (n >= 200) fail_timeout("send_cmd");
    bus.cmd_valid = 1'b1; bus.cmd_addr = a; bus.cmd_len = LEN_W'(len);
    bus.cmd_size = SIZE_W'(size); bus.cmd_burst = 2'(burst);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [1:0] resp, input bit last);
    int n = 0;
    while (mq.size() >= 2 && n < 200) begin tick(); n++; end
    if (n >= 200) fail_timeout("send_beat");
    bus.rvalid = 1'b1; bus.rdata = d; bus.rresp = resp; bus.rlast = last;
    tick();
  endtask

  task automatic drain();
    int n = 0;
    bus.cmd_valid = 1'b0; bus.arready = 1'b1; bus.out_ready = 1'b1;
    while ((m_arv || m_out > 0 || mq.size() > 0) && n < 2000) begin
      slave_step(100); tick(); n++;
    end
    if (n >= 2000) fail_timeout("drain");
    bus.arready = 1'b0;
  endtask

  task automatic plan1();
    bus.out_ready = 1'b1; bus.arready = 1'b0;
    send_cmd(32'h100, 3, 2, 1);
    chk("p1_arvalid", bus.arvalid, 1);
    chk("p1_araddr", bus.araddr, 32'h100);
    chk("p1_arlen", bus.arlen, 3);
    bus.arready = 1'b1; tick(); bus.arready = 1'b0;
    chk("p1_outst1", outstanding, 1);
    for (int i = 0; i < 4; i++) begin
      send_beat(32'hA000 + i, 2'b00, i == 3);
      chk("p1_beat", bus.out_data, 32'hA000 + i);
      chk("p1_last", bus.out_last, i == 3);
    end
    tick();
    chk("p1_outst0", outstanding, 0);
    chk("p1_resp_err", resp_err_cnt, 0);
    chk("p1_empty", bus.out_valid, 0);
    sq.delete(); s_beat = 0;
  endtask

  vec_t tbl[12];

  initial begin
    int acc, rec0;
    tbl[0]  = '{32'h40,  2, 2, 2, 1'b1};  // WRAP len 2
    tbl[1]  = '{32'hFF8, 3, 2, 1, 1'b1};  // INCR crosses 4 KB
    tbl[2]  = '{32'h0,   0, 0, 3, 1'b1};  // reserved burst
    tbl[3]  = '{32'h0,   0, 3, 1, 1'b1};  // size wider than bus
    tbl[4]  = '{32'h44,  3, 2, 2, 1'b0};  // aligned WRAP 4
    tbl[5]  = '{32'h42,  3, 2, 2, 1'b1};  // misaligned WRAP
    tbl[6]  = '{32'hFF0, 3, 2, 1, 1'b0};  // INCR ends exactly at 4 KB
    tbl[7]  = '{32'h123, 1, 0, 0, 1'b0};  // FIXED
    tbl[8]  = '{32'hFFF, 0, 0, 1, 1'b0};  // last byte of page
    tbl[9]  = '{32'h80, 15, 1, 2, 1'b0};  // WRAP 16
    tbl[10] = '{32'h80,  0, 2, 2, 1'b1};  // WRAP len 0
    tbl[11] = '{32'h1F00, 7, 2, 1, 1'b0}; // INCR mid page

    bus.cmd_valid = 0; bus.cmd_addr = '0; bus.cmd_len = '0; bus.cmd_size = '0; bus.cmd_burst = '0;
    bus.arready = 0; bus.rvalid = 0; bus.rdata = '0; bus.rresp = '0; bus.rlast = 0; bus.out_ready = 0;
    err_pct = 0; dut_ar_cnt = 0; dut_r_cnt = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    chk("rst_arvalid", bus.arvalid, 0);
    chk("rst_araddr", bus.araddr, 0);
    chk("rst_rready", bus.rready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_resp_err", resp_err_cnt, 0);
    chk("rst_proto", proto_err, 0);
    chk("rst_cmd_err", cmd_err, 0);
    reset_n = 1'b1;

    plan1();

    for (int i = 0; i < 12; i++) begin
      bus.arready = 1'b0;
      send_cmd(tbl[i].addr, tbl[i].len, tbl[i].size, tbl[i].burst);
      chk($sformatf("tbl%0d_cmd_err", i), cmd_err, tbl[i].err);
      chk($sformatf("tbl%0d_arvalid", i), bus.arvalid, !tbl[i].err);
      tick();
      chk($sformatf("tbl%0d_err_pulse", i), cmd_err, 0);
      drain();
    end

    // MAX_OUT back-to-back commands, fifth waits for a retirement
    bus.arready = 1'b1; bus.out_ready = 1'b1; dut_ar_cnt = 0; acc = 0;
    bus.cmd_addr = 32'h200; bus.cmd_len = '0; bus.cmd_size = 3'd2; bus.cmd_burst = 2'b01;
    for (int c = 0; c < 40 && acc < 4; c++) begin
      bus.cmd_valid = 1'b1;
      if (model_crdy()) acc++;
      tick();
    end
    bus.cmd_valid = 1'b0;
    repeat (3) tick();
    chk("b2b_ar_cnt", dut_ar_cnt, 4);
    chk("b2b_outst", outstanding, 4);
    chk("b2b_cmd_ready", bus.cmd_ready, 0);
    bus.cmd_valid = 1'b1;
    repeat (3) tick();
    chk("b2b_5th_blocked", bus.arvalid, 0);
    send_beat(32'hB0, 2'b00, 1'b1);
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    chk("b2b_5th_issued", dut_ar_cnt, 5);
    chk("b2b_outst_after", outstanding, 4);
    drain();

    // backpressure on out_* during a len-7 burst
    bus.out_ready = 1'b0; bus.arready = 1'b1; dut_r_cnt = 0;
    send_cmd(32'h300, 7, 2, 1);
    for (int c = 0; c < 10; c++) begin slave_step(100); tick(); end
    chk("bp_rready_low", bus.rready, 0);
    chk("bp_r_hs", dut_r_cnt, 2);
    chk("bp_out_valid", bus.out_valid, 1);
    drain();
    chk("bp_total_beats", dut_r_cnt, 8);

    // early rlast with error responses
    rec0 = m_rec;
    bus.arready = 1'b1; bus.out_ready = 1'b1;
    send_cmd(32'h400, 3, 2, 1);
    tick();
    send_beat(32'hC0, 2'b10, 1'b0);
    send_beat(32'hC1, 2'b10, 1'b1);
    chk("pe_proto", proto_err, PROTO_EXP);
    send_beat(32'hC2, 2'b10, 1'b0);
    send_beat(32'hC3, 2'b10, 1'b1);
    tick();
    chk("pe_proto_sticky", proto_err, PROTO_EXP);
    chk("pe_resp_err", resp_err_cnt, rec0 + 4);
    chk("pe_outst", outstanding, 0);
    sq.delete(); s_beat = 0; bus.arready = 1'b0;

    // random traffic
    err_pct = 20;
    for (int c = 0; c < 3000; c++) begin
      bus.cmd_valid = int'($urandom_range(99)) < 30;
      bus.cmd_burst = 2'($urandom_range(3));
      bus.cmd_size  = 3'($urandom_range(3));
      bus.cmd_len   = ($urandom_range(3) == 0) ? 8'($urandom_range(255)) : 8'((1 << $urandom_range(4)) - 1);
      bus.cmd_addr  = $urandom;
      if ($urandom_range(1) == 1) bus.cmd_addr[11:0] = 12'hFC0 + 12'($urandom_range(63));
      bus.arready   = int'($urandom_range(99)) < 60;
      bus.out_ready = int'($urandom_range(99)) < 70;
      slave_step(60);
      tick();
    end
    drain();
    err_pct = 0;

    // asynchronous reset with a beat held in the buffer
    bus.arready = 1'b1; bus.out_ready = 1'b0;
    send_cmd(32'h500, 3, 2, 1);
    tick();
    send_beat(32'hD0, 2'b00, 1'b0);
    chk("mr_buffered", bus.out_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("mr_cmd_ready", bus.cmd_ready, 0);
    chk("mr_arvalid", bus.arvalid, 0);
    chk("mr_araddr", bus.araddr, 0);
    chk("mr_arlen", bus.arlen, 0);
    chk("mr_rready", bus.rready, 0);
    chk("mr_out_valid", bus.out_valid, 0);
    chk("mr_out_data", bus.out_data, 0);
    chk("mr_outstanding", outstanding, 0);
    chk("mr_resp_err", resp_err_cnt, 0);
    chk("mr_proto", proto_err, 0);
    chk("mr_cmd_err", cmd_err, 0);
    bus.rvalid = 1'b0; bus.cmd_valid = 1'b0; bus.arready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    plan1();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
